// File: rtl/input_window_scheduler_pkg.sv
// input_window_scheduler_pkg: shared FSM encoding and scratchpad depth for the window scheduler and PE-side reader
package input_window_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, FILL, READY, SLIDE} win_state_t;
  localparam int SCRATCH_DEPTH_DEF = 4;
endpackage

// File: rtl/input_window_scheduler_mod_depth_ptr.sv
// mod_depth_ptr: scratchpad pointer wrapping modulo a power-of-2 depth, with load, increment and add-step
module mod_depth_ptr #(
  parameter int DEPTH = 4,
  localparam int W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         add,
  input  logic [W:0]   step,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else ptr <= load ? load_val : W'({1'b0, ptr} + (add ? step : (W+1)'(inc)));
endmodule

// File: rtl/input_window_scheduler.sv
// input_window_scheduler: fills a circular scratchpad from a show-ahead FIFO so the PE array sees complete sliding windows
module input_window_scheduler
  import input_window_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SCRATCH_DEPTH = SCRATCH_DEPTH_DEF,
  parameter int CNT_W = 8,
  localparam int ADDR_W = $clog2(SCRATCH_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   win_len,
  input  logic [ADDR_W:0]   stride,
  input  logic [CNT_W-1:0]  n_windows,
  input  logic              fifo_empty,
  input  logic              consumer_done,
  output logic              fifo_ren,
  output logic              scratch_wen,
  output logic [ADDR_W-1:0] scratch_waddr,
  output logic [ADDR_W-1:0] win_base,
  output logic              window_valid,
  output logic              busy,
  output logic              job_done
);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  if (DATA_WIDTH < 1 || SCRATCH_DEPTH < 2 || (SCRATCH_DEPTH & (SCRATCH_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("input_window_scheduler: invalid DATA_WIDTH or SCRATCH_DEPTH");
  end
  win_state_t state;
  logic [ADDR_W:0] remaining, stride_q, wl_c, st_c;
  logic [CNT_W-1:0] nwin_q, windows_done, nw_c;
  logic [ADDR_W-1:0] wptr, base;
  logic wr, start_ok, last_win, slide;
  always_comb begin
    wr = (state == FILL || state == SLIDE) && remaining != '0 && !fifo_empty;
    start_ok = state == IDLE && start;
    last_win = windows_done == CNT_W'(nwin_q - CNT_W'(1));
    slide = state == READY && consumer_done && !last_win;
    wl_c = win_len == '0 ? ONE : (win_len > DEPTH_V ? DEPTH_V : win_len);
    st_c = stride == '0 ? ONE : (stride > wl_c ? wl_c : stride);
    nw_c = n_windows == '0 ? CNT_W'(1) : n_windows;
  end
  assign fifo_ren = wr;
  assign scratch_wen = wr;
  assign scratch_waddr = wptr;
  assign win_base = base;
  assign window_valid = state == READY;
  assign busy = state != IDLE;
  mod_depth_ptr #(.DEPTH(SCRATCH_DEPTH)) u_wptr (
    .clk(clk), .rst(rst), .load(start_ok), .load_val('0), .inc(wr), .add(1'b0), .step('0), .ptr(wptr)
  );
  mod_depth_ptr #(.DEPTH(SCRATCH_DEPTH)) u_base (
    .clk(clk), .rst(rst), .load(start_ok), .load_val('0), .inc(1'b0), .add(slide), .step(stride_q), .ptr(base)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      stride_q <= '0;
      nwin_q <= '0;
      windows_done <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            remaining <= wl_c;
            stride_q <= st_c;
            nwin_q <= nw_c;
            windows_done <= '0;
            state <= FILL;
          end
        FILL, SLIDE:
          if (wr) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) state <= READY;
          end
        READY:
          if (consumer_done) begin
            windows_done <= windows_done + CNT_W'(1);
            if (last_win) begin
              job_done <= 1'b1;
              state <= IDLE;
            end else begin
              remaining <= stride_q;
              state <= SLIDE;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_input_window_scheduler.sv
// tb_input_window_scheduler: table-driven, hand-sequenced and randomized checks of the window scheduler against a window-arithmetic model
module tb_input_window_scheduler;
  localparam int D = 4;
  localparam int AW = 2;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, fifo_empty = 1'b1, consumer_done = 1'b0;
  logic [AW:0] win_len = '0, stride = '0;
  logic [CW-1:0] n_windows = '0;
  logic fifo_ren, scratch_wen, window_valid, busy, job_done;
  logic [AW-1:0] scratch_waddr, win_base;
  int checks = 0, errors = 0;
  typedef struct {int wl; int st; int nw; int pct; int exp_writes; int exp_base; string name;} vec_t;
  vec_t tbl[9];
  int st_empty[7] = '{0, 1, 1, 1, 0, 0, 0};
  int st_addr[7] = '{0, -1, -1, -1, 1, 2, 3};
  always #5 clk = ~clk;
  input_window_scheduler #(.DATA_WIDTH(16), .SCRATCH_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .stride(stride), .n_windows(n_windows),
    .fifo_empty(fifo_empty), .consumer_done(consumer_done), .fifo_ren(fifo_ren), .scratch_wen(scratch_wen),
    .scratch_waddr(scratch_waddr), .win_base(win_base), .window_valid(window_valid), .busy(busy), .job_done(job_done)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #3;
  endtask
  // Element number n of a job always lands at n mod D; window k spans elements k*st .. k*st+wl-1.
  task automatic run_job(input int wl_in, input int st_in, input int nw_in, input int pct, output int writes, output int last_base);
    int wl, st, nw, total, budget, hold;
    wl = wl_in == 0 ? 1 : (wl_in > D ? D : wl_in);
    st = st_in == 0 ? 1 : (st_in > wl ? wl : st_in);
    nw = nw_in == 0 ? 1 : nw_in;
    total = 0;
    last_base = 0;
    writes = 0;
    cyc();
    start = 1'b1; win_len = AW'(0) | wl_in[AW:0]; stride = st_in[AW:0]; n_windows = nw_in[CW-1:0];
    fifo_empty = 1'b0; consumer_done = 1'b0;
    settle();
    chk("idle_busy", busy, 0);
    for (int k = 0; k < nw; k++) begin
      budget = 0;
      while (total < wl + k * st && budget < 300) begin
        cyc();
        start = $urandom_range(3) == 0;
        win_len = AW'($urandom) | 3'($urandom_range(7));
        stride = 3'($urandom_range(7));
        n_windows = 8'($urandom);
        fifo_empty = $urandom_range(99) < pct;
        consumer_done = $urandom_range(4) == 0;
        settle();
        chk("fill_wen", scratch_wen, !fifo_empty);
        chk("fill_ren", fifo_ren, scratch_wen);
        chk("fill_valid", window_valid, 0);
        chk("fill_busy", busy, 1);
        chk("fill_job_done", job_done, 0);
        if (scratch_wen) begin
          chk("fill_waddr", scratch_waddr, total % D);
          total++;
        end
        budget++;
      end
      if (budget >= 300) begin
        chk("fill_timeout", total, wl + k * st);
        rst = 1'b1; cyc(); rst = 1'b0; start = 1'b0;
        writes = total;
        return;
      end
      hold = $urandom_range(3);
      for (int h = 0; h <= hold; h++) begin
        cyc();
        start = $urandom_range(1);
        win_len = 3'($urandom_range(7));
        fifo_empty = $urandom_range(1);
        consumer_done = h == hold;
        settle();
        chk("ready_valid", window_valid, 1);
        chk("ready_base", win_base, (k * st) % D);
        chk("ready_wen", scratch_wen, 0);
        chk("ready_ren", fifo_ren, 0);
      end
      last_base = (k * st) % D;
    end
    cyc();
    start = 1'b0; consumer_done = 1'b0;
    settle();
    chk("end_job_done", job_done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", window_valid, 0);
    cyc();
    settle();
    chk("end_job_done_pulse", job_done, 0);
    writes = total;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int w, b;
    tbl[0] = '{3, 1, 1, 0, 3, 0, "basic_fill"};
    tbl[1] = '{3, 1, 3, 0, 5, 2, "slide_stride1"};
    tbl[2] = '{4, 4, 2, 0, 8, 0, "full_stride_wrap"};
    tbl[3] = '{4, 1, 1, 50, 4, 0, "fill_random_stall"};
    tbl[4] = '{0, 0, 0, 0, 1, 0, "clamp_zero"};
    tbl[5] = '{7, 5, 2, 0, 8, 0, "clamp_high"};
    tbl[6] = '{2, 3, 3, 20, 6, 0, "clamp_stride"};
    tbl[7] = '{3, 2, 4, 30, 9, 2, "stride2"};
    tbl[8] = '{1, 1, 5, 10, 5, 0, "win_len1"};
    repeat (2) cyc();
    settle();
    chk("rst_ren", fifo_ren, 0);
    chk("rst_wen", scratch_wen, 0);
    chk("rst_waddr", scratch_waddr, 0);
    chk("rst_base", win_base, 0);
    chk("rst_valid", window_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_done", job_done, 0);
    cyc();
    rst = 1'b0;
    foreach (tbl[i]) begin
      run_job(tbl[i].wl, tbl[i].st, tbl[i].nw, tbl[i].pct, w, b);
      chk({tbl[i].name, "_writes"}, w, tbl[i].exp_writes);
      chk({tbl[i].name, "_base"}, b, tbl[i].exp_base);
    end
    // FIFO empty on cycles 2..4 of a 4-element fill
    cyc();
    start = 1'b1; win_len = 3'd4; stride = 3'd1; n_windows = 8'd1; fifo_empty = 1'b0; consumer_done = 1'b0;
    settle();
    for (int c = 0; c < 7; c++) begin
      cyc();
      start = 1'b0;
      fifo_empty = st_empty[c] != 0;
      settle();
      chk("stall_wen", scratch_wen, st_empty[c] == 0);
      chk("stall_ren", fifo_ren, st_empty[c] == 0);
      if (st_addr[c] >= 0) chk("stall_waddr", scratch_waddr, st_addr[c]);
      chk("stall_valid", window_valid, 0);
    end
    cyc();
    fifo_empty = 1'b1;
    settle();
    chk("stall_ready", window_valid, 1);
    cyc();
    consumer_done = 1'b1; fifo_empty = 1'b0;
    settle();
    chk("stall_ready_hold", window_valid, 1);
    cyc();
    consumer_done = 1'b0;
    settle();
    chk("stall_job_done", job_done, 1);
    chk("stall_busy", busy, 0);
    // async reset while stalled in SLIDE
    cyc();
    start = 1'b1; win_len = 3'd3; stride = 3'd1; n_windows = 8'd3; fifo_empty = 1'b0;
    settle();
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    consumer_done = 1'b1;
    settle();
    chk("ar_ready", window_valid, 1);
    cyc();
    consumer_done = 1'b0; fifo_empty = 1'b1;
    settle();
    chk("ar_slide_busy", busy, 1);
    chk("ar_slide_base", win_base, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_base", win_base, 0);
    chk("ar_waddr", scratch_waddr, 0);
    chk("ar_valid", window_valid, 0);
    chk("ar_ren", fifo_ren, 0);
    cyc();
    rst = 1'b0;
    run_job(2, 1, 1, 0, w, b);
    chk("ar_restart_writes", w, 2);
    repeat (30) begin
      run_job($urandom_range(7), $urandom_range(7), $urandom_range(5), $urandom_range(60), w, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_window_scheduler.md
Name: input_window_scheduler

Overview:
- Sequences transfers from the input FIFO buffer into a circular scratchpad so the PE array always sees a complete sliding window of WIN_LEN elements.
- Fills the first window, then for each consumer release refills only STRIDE new elements, overwriting the oldest entries.
- Sits between the input FIFO (show-ahead, empty flag) and the scratchpad write port. Replaces ad-hoc counting of scratch writes.

Parameters:
- DATA_WIDTH, 16, element width. Data passes outside this block; the parameter is kept for uniform instantiation.
- SCRATCH_DEPTH, 4, number of scratchpad entries. Must be a power of 2, at least 2.
- ADDR_W, $clog2(SCRATCH_DEPTH), scratchpad address width (localparam).
- CNT_W, 8, width of the window-count input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  1-cycle pulse; begins a job (ignored unless IDLE)
- win_len  in  ADDR_W+1  window length, 1..SCRATCH_DEPTH, sampled at start
- stride  in  ADDR_W+1  slide step, 1..win_len, sampled at start
- n_windows  in  CNT_W  windows in the job, at least 1, sampled at start
- fifo_empty  in  1  FIFO empty flag
- consumer_done  in  1  1-cycle pulse; PE finished with the current window
- fifo_ren  out  1  FIFO pop
- scratch_wen  out  1  scratchpad write strobe
- scratch_waddr  out  ADDR_W  scratchpad write address
- win_base  out  ADDR_W  scratch address of the oldest element of the current window
- window_valid  out  1  current window complete and stable
- busy  out  1  state is not IDLE
- job_done  out  1  1-cycle pulse after the last window is released

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; write pointer, base, remaining-fill and window counters = 0.
- FSM states: IDLE, FILL, READY, SLIDE.
- IDLE:
  - On start: latch win_len/stride/n_windows; remaining = win_len; wptr = 0; base = 0; go to FILL.
- FILL / SLIDE:
  - fifo_ren = scratch_wen = (remaining != 0) & ~fifo_empty, combinational in the same cycle. The FIFO is show-ahead, so data is valid with ren.
  - scratch_waddr = wptr.
  - Each write: wptr = wptr+1 mod SCRATCH_DEPTH; remaining-1.
  - When the last element is written (remaining==1 and write), go to READY on the next edge.
  - fifo_empty stalls with no write, no pointer change, and no timeout.
- READY:
  - window_valid = 1; win_base stable.
  - On consumer_done: windows_done+1.
    - If windows_done+1 == n_windows: job_done = 1 for one cycle (registered, cycle after the pulse); go to IDLE.
    - Else: base = base+stride mod SCRATCH_DEPTH; remaining = stride; go to SLIDE.
- Latency: window_valid rises exactly 1 cycle after the final scratch_wen.
- window_valid drops the cycle after consumer_done.
- Ignored events:
  - start while busy.
  - consumer_done outside READY.
  - fifo_empty while remaining == 0, which issues no ren.
- Wrap-around: wptr and base wrap modulo SCRATCH_DEPTH. With win_len == SCRATCH_DEPTH and stride == win_len, each slide rewrites the whole scratchpad.
- Reset mid-operation: immediate return to IDLE. Elements already popped are lost; upstream must reset the FIFO together with this block.
- Out-of-range configuration (win_len 0 or > depth, stride 0 or > win_len) is clamped at the start sample:
  - win_len to [1, SCRATCH_DEPTH];
  - stride to [1, win_len];
  - n_windows 0 treated as 1.

Decomposition:
- Shared package: FSM state enum (IDLE/FILL/READY/SLIDE) and the SCRATCH_DEPTH default, so the PE-side read controller uses identical encoding and depth.
- One natural sub-module: mod_depth_ptr, a wrapping pointer with load, increment and add-stride, instantiated for wptr and base.
- Counters and FSM stay in the top module.

Test Plan:
- Basic fill:
  - Stimulus: depth 4, win_len=3, stride=1, n_windows=1, fifo_empty=0, start.
  - Response: scratch_wen on 3 consecutive cycles, addr 0,1,2; window_valid the next cycle; consumer_done produces job_done 1 cycle later, then busy=0.
- Sliding:
  - Stimulus: win_len=3, stride=1, n_windows=3.
  - Response: after each consumer_done exactly 1 write, addresses 3 then 0 (wrap); win_base 0 → 1 → 2; job_done after the third done.
- FIFO stall:
  - Stimulus: win_len=4; fifo_empty=1 for cycles 2..4 of the fill.
  - Response: no fifo_ren/scratch_wen while empty; addresses continue contiguously (0,1,2,3); window_valid only after the 4th write.
- Full-stride wrap:
  - Stimulus: win_len=4, stride=4, n_windows=2.
  - Response: second fill writes addr 0..3 again; win_base stays 0.
- Ignored inputs:
  - Stimulus: consumer_done during FILL; start during READY.
  - Response: no state, counter or pointer change.
- Async reset:
  - Stimulus: assert rst mid-SLIDE, asynchronously between edges.
  - Response: all outputs 0 immediately; after release, a new start fills from addr 0.
